// File: rtl/threat_pkg.sv
// Field layout, direction codes and record type for the threat-report receive path.
// Shared by the decoder top and its record FIFO.
package threat_pkg;

    localparam int WORD_W     = 128;
    localparam int PAD_HI_LSB = 112;
    localparam int DIR_LSB    = 104;
    localparam int PAD_LO_LSB = 99;
    localparam int FLAG_LSB   = 96;
    localparam int PORT_LSB   = 80;
    localparam int MAC_LSB    = 32;
    localparam int IP_LSB     = 0;

    localparam logic [7:0] DIR_P1_TO_P2 = 8'h01;
    localparam logic [7:0] DIR_P2_TO_P1 = 8'h02;

    localparam int FLAG_PSCAN = 0;
    localparam int FLAG_ARP   = 1;
    localparam int FLAG_DDOS  = 2;

    typedef struct packed {
        logic        dir;
        logic [2:0]  flags;
        logic [15:0] port;
        logic [47:0] mac;
        logic [31:0] ip;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    function automatic logic word_valid(input logic [WORD_W-1:0] w);
        return (w[PAD_HI_LSB +: 16] == '0) && (w[PAD_LO_LSB +: 5] == '0)
            && ((w[DIR_LSB +: 8] == DIR_P1_TO_P2) || (w[DIR_LSB +: 8] == DIR_P2_TO_P1))
            && (w[FLAG_LSB +: 3] != 3'b000);
    endfunction

    function automatic rec_t unpack_word(input logic [WORD_W-1:0] w);
        rec_t r;
        r       = '0;
        r.dir   = (w[DIR_LSB +: 8] == DIR_P2_TO_P1);
        r.flags = w[FLAG_LSB +: 3];
        r.port  = w[PORT_LSB +: 16];
        r.mac   = w[MAC_LSB +: 48];
        r.ip    = w[IP_LSB +: 32];
        return r;
    endfunction

endpackage

// File: rtl/threat_rec_fifo.sv
// Synchronous show-ahead record FIFO: head is visible on dout while not empty, zero when empty.
// Simultaneous push and pop while full both take effect.
module threat_rec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 100
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: storage is not reset; pointers and level define validity and dout is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/threat_report_decoder.sv
// Threat-report receive end: dedupe, validate, unpack and buffer records for a valid/ready sink.
// Define THREAT_STATS_EN to add saturating per-event statistics counters and stat_clr.
module threat_report_decoder
    import threat_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef THREAT_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [127:0]           data_in,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic                   rec_dir,
    output logic [2:0]             rec_flags,
    output logic [15:0]            rec_port,
    output logic [47:0]            rec_mac,
    output logic [31:0]            rec_ip,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   malformed
`ifdef THREAT_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [CNT_W-1:0]       cnt_ddos,
    output logic [CNT_W-1:0]       cnt_arp,
    output logic [CNT_W-1:0]       cnt_pscan,
    output logic [CNT_W-1:0]       cnt_malformed,
    output logic [CNT_W-1:0]       cnt_drop
`endif
);

    logic [WORD_W-1:0] s1_word;
    logic              s1_new;
    logic              s1_ok;
    logic              push;
    logic              bad;
    logic              pop;
    logic              drop;
    logic              empty;
    logic              full;
    rec_t              push_rec;
    rec_t              head_rec;

    // s1_word doubles as the previous-word register, so a zero word clears the dedupe history.
    // NOTE: non-blocking assignments make s1_new compare against the pre-edge s1_word.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1_word <= '0;
            s1_new  <= 1'b0;
        end else begin
            s1_new  <= (data_in != '0) && (data_in != s1_word);
            s1_word <= data_in;
        end
    end

    assign s1_ok    = word_valid(s1_word);
    assign push     = s1_new && s1_ok;
    assign bad      = s1_new && !s1_ok;
    assign push_rec = unpack_word(s1_word);
    assign pop      = rec_ready && !empty;
    assign drop     = push && full && !pop;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            malformed <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            malformed <= bad;
            overflow  <= overflow || drop;
        end
    end

    threat_rec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head_rec),
        .empty (empty),
        .full  (full),
        .level (fifo_level)
    );

    assign rec_valid = !empty;
    assign rec_dir   = head_rec.dir;
    assign rec_flags = head_rec.flags;
    assign rec_port  = head_rec.port;
    assign rec_mac   = head_rec.mac;
    assign rec_ip    = head_rec.ip;

`ifdef THREAT_STATS_EN
    logic enq;
    assign enq = push && !drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Clear shares priority with reset so it wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!n_rst || stat_clr) begin
            cnt_ddos      <= '0;
            cnt_arp       <= '0;
            cnt_pscan     <= '0;
            cnt_malformed <= '0;
            cnt_drop      <= '0;
        end else begin
            cnt_ddos      <= sat_inc(cnt_ddos,  enq && push_rec.flags[FLAG_DDOS]);
            cnt_arp       <= sat_inc(cnt_arp,   enq && push_rec.flags[FLAG_ARP]);
            cnt_pscan     <= sat_inc(cnt_pscan, enq && push_rec.flags[FLAG_PSCAN]);
            cnt_malformed <= sat_inc(cnt_malformed, bad);
            cnt_drop      <= sat_inc(cnt_drop, drop);
        end
    end
`endif

endmodule

// File: tb/tb_threat_report_decoder.sv
// Self-checking bench for threat_report_decoder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_threat_report_decoder;

    localparam int DEPTH = 8;
`ifdef THREAT_STATS_EN
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic                   clk = 1'b0;
    logic                   n_rst;
    logic [127:0]           data_in;
    logic                   rec_ready;
    logic                   rec_valid;
    logic                   rec_dir;
    logic [2:0]             rec_flags;
    logic [15:0]            rec_port;
    logic [47:0]            rec_mac;
    logic [31:0]            rec_ip;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   malformed;
`ifdef THREAT_STATS_EN
    logic                   stat_clr;
    logic [CNT_W-1:0]       cnt_ddos, cnt_arp, cnt_pscan, cnt_malformed, cnt_drop;
`endif

    always #5 clk = ~clk;

    threat_report_decoder #(
        .DEPTH (DEPTH)
`ifdef THREAT_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_in    (data_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_dir    (rec_dir),
        .rec_flags  (rec_flags),
        .rec_port   (rec_port),
        .rec_mac    (rec_mac),
        .rec_ip     (rec_ip),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .malformed  (malformed)
`ifdef THREAT_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .cnt_ddos      (cnt_ddos),
        .cnt_arp       (cnt_arp),
        .cnt_pscan     (cnt_pscan),
        .cnt_malformed (cnt_malformed),
        .cnt_drop      (cnt_drop)
`endif
    );

    typedef struct packed {
        logic        dir;
        logic [2:0]  flags;
        logic [15:0] port;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_rec_t;

    typedef struct {
        logic [127:0] word;
        logic         exp_rec;
        logic         exp_mal;
        logic         exp_dir;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    exp_rec_t     mq[$];
    logic [127:0] m_prev;
    int           p1_kind;
    exp_rec_t     p1_rec;
    logic         m_ovf;
    logic         m_mal;
    int           m_ddos, m_arp, m_pscan, m_malc, m_drop;

    vec_t         vecs[7];
    int           exp_ports[8];
    logic [127:0] w1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] code, input logic [2:0] flags,
                                               input logic [15:0] port, input logic [47:0] mac,
                                               input logic [31:0] ip);
        return {16'h0000, code, 5'b00000, flags, port, mac, ip};
    endfunction

    function automatic bit spec_valid(input logic [127:0] w);
        logic [7:0] code;
        code = w[111:104];
        return (w[127:112] == 16'h0) && (w[103:99] == 5'h0)
            && (code == 8'h01 || code == 8'h02) && (w[98:96] != 3'b000);
    endfunction

    function automatic exp_rec_t spec_rec(input logic [127:0] w);
        exp_rec_t r;
        r.dir   = (w[111:104] == 8'h02);
        r.flags = w[98:96];
        r.port  = w[95:80];
        r.mac   = w[79:32];
        r.ip    = w[31:0];
        return r;
    endfunction

`ifdef THREAT_STATS_EN
    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction
`endif

    task automatic do_reset();
        n_rst     = 1'b0;
        data_in   = '0;
        rec_ready = 1'b0;
`ifdef THREAT_STATS_EN
        stat_clr  = 1'b0;
`endif
        step();
        step();
        n_rst = 1'b1;
        mq.delete();
        m_prev  = '0;
        p1_kind = 0;
        p1_rec  = '0;
        m_ovf   = 1'b0;
        m_mal   = 1'b0;
        m_ddos  = 0; m_arp = 0; m_pscan = 0; m_malc = 0; m_drop = 0;
    endtask

    // Advance the model across one clock edge with the current inputs, then clock the DUT.
    task automatic model_and_step();
        int kind;
        if (rec_ready && mq.size() > 0) void'(mq.pop_front());
        m_mal = (p1_kind == 2);
        if (m_mal) m_malc++;
        if (p1_kind == 1) begin
            if (mq.size() == DEPTH) begin
                m_ovf = 1'b1;
                m_drop++;
            end else begin
                mq.push_back(p1_rec);
                if (p1_rec.flags[2]) m_ddos++;
                if (p1_rec.flags[1]) m_arp++;
                if (p1_rec.flags[0]) m_pscan++;
            end
        end
        kind = 0;
        if (data_in != '0 && data_in != m_prev) kind = spec_valid(data_in) ? 1 : 2;
        m_prev  = data_in;
        p1_kind = kind;
        p1_rec  = spec_rec(data_in);
        step();
    endtask

    task automatic compare_model();
        exp_rec_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        check("rnd_valid", rec_valid, mq.size() > 0);
        check("rnd_level", fifo_level, mq.size());
        check("rnd_overflow", overflow, m_ovf);
        check("rnd_malformed", malformed, m_mal);
        check("rnd_head", {rec_dir, rec_flags, rec_port, rec_mac, rec_ip}, h);
`ifdef THREAT_STATS_EN
        check("rnd_cnt_ddos", cnt_ddos, sat(m_ddos));
        check("rnd_cnt_arp", cnt_arp, sat(m_arp));
        check("rnd_cnt_pscan", cnt_pscan, sat(m_pscan));
        check("rnd_cnt_malformed", cnt_malformed, sat(m_malc));
        check("rnd_cnt_drop", cnt_drop, sat(m_drop));
`endif
    endtask

    initial begin
        w1 = make_word(8'h01, 3'b100, 16'h0050, 48'h0011_2233_4455, 32'hC0A8_0001);
        vecs[0] = '{make_word(8'h01, 3'b100, 16'h1111, 48'h1, 32'h1), 1'b1, 1'b0, 1'b0};
        vecs[1] = '{make_word(8'h02, 3'b011, 16'h2222, 48'h2, 32'h2), 1'b1, 1'b0, 1'b1};
        vecs[2] = '{make_word(8'h03, 3'b100, 16'h3333, 48'h3, 32'h3), 1'b0, 1'b1, 1'b0};
        vecs[3] = '{make_word(8'h01, 3'b001, 16'h4444, 48'h4, 32'h4) | (128'h1 << 100), 1'b0, 1'b1, 1'b0};
        vecs[4] = '{make_word(8'h01, 3'b000, 16'h5555, 48'h5, 32'h5), 1'b0, 1'b1, 1'b0};
        vecs[5] = '{make_word(8'h02, 3'b010, 16'h6666, 48'h6, 32'h6) | (128'h1 << 127), 1'b0, 1'b1, 1'b0};
        vecs[6] = '{make_word(8'h00, 3'b111, 16'h7777, 48'h7, 32'h7), 1'b0, 1'b1, 1'b0};
        exp_ports = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd100};

        // Reset state
        do_reset();
        check("rst_valid", rec_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_malformed", malformed, 0);
        check("rst_fields", {rec_dir, rec_flags, rec_port, rec_mac, rec_ip}, 0);

        // Two-cycle latency and exact field unpacking
        data_in = w1;
        step();
        data_in = '0;
        check("lat_n1_valid", rec_valid, 0);
        step();
        check("lat_valid", rec_valid, 1);
        check("lat_dir", rec_dir, 0);
        check("lat_flags", rec_flags, 3'b100);
        check("lat_port", rec_port, 16'h0050);
        check("lat_mac", rec_mac, 48'h0011_2233_4455);
        check("lat_ip", rec_ip, 32'hC0A8_0001);
        check("lat_level", fifo_level, 1);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("lat_pop_valid", rec_valid, 0);
        check("lat_pop_zero", {rec_dir, rec_flags, rec_port, rec_mac, rec_ip}, 0);

        // Held word yields one record; a gap makes the same word new again
        data_in = w1;
        repeat (5) step();
        data_in = '0;
        step();
        step();
        check("dup_level_one", fifo_level, 1);
        data_in = w1;
        step();
        data_in = '0;
        step();
        check("dup_regap_level", fifo_level, 2);
        rec_ready = 1'b1;
        step();
        step();
        rec_ready = 1'b0;
        check("dup_drained", fifo_level, 0);

        // Validation table
        for (int i = 0; i < 7; i++) begin
            data_in = vecs[i].word;
            step();
            data_in = '0;
            step();
            check($sformatf("vec%0d_malformed", i), malformed, vecs[i].exp_mal);
            check($sformatf("vec%0d_valid", i), rec_valid, vecs[i].exp_rec);
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_rec ? 1 : 0);
            if (vecs[i].exp_rec) check($sformatf("vec%0d_dir", i), rec_dir, vecs[i].exp_dir);
            rec_ready = 1'b1;
            step();
            rec_ready = 1'b0;
            check($sformatf("vec%0d_pulse_end", i), malformed, 0);
            check($sformatf("vec%0d_drained", i), fifo_level, 0);
        end

        // Nine distinct words with the consumer stalled
        for (int i = 0; i < 9; i++) begin
            data_in = make_word(8'h01, 3'b001, 16'(i + 1), 48'hA5, 32'(i));
            step();
        end
        data_in = '0;
        step();
        step();
        check("ovf_level", fifo_level, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rec_port, 1);
        step();
        check("ovf_hold_port", rec_port, 1);

        // Push and pop together while full
        data_in = make_word(8'h02, 3'b010, 16'd100, 48'hB6, 32'd100);
        step();
        data_in = '0;
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("fullpop_level", fifo_level, DEPTH);
        rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("order%0d_port", k), rec_port, exp_ports[k]);
            step();
        end
        rec_ready = 1'b0;
        check("order_drained", fifo_level, 0);
        check("ovf_sticky", overflow, 1);

        // Reset with one record held and one in flight
        data_in = make_word(8'h02, 3'b001, 16'd7, 48'h7, 32'h7);
        step();
        data_in = w1;
        step();
        data_in = '0;
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        check("rstmid_level", fifo_level, 0);
        check("rstmid_overflow", overflow, 0);
        step();
        check("rstmid_inflight", rec_valid, 0);

`ifdef THREAT_STATS_EN
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = make_word(8'h01, 3'b100, 16'(i), 48'h1, 32'h1);
            step();
        end
        data_in = '0;
        step();
        step();
        check("stat_ddos_sat", cnt_ddos, CNT_MAX);
        check("stat_arp_zero", cnt_arp, 0);
        check("stat_drop_zero", cnt_drop, 0);
        data_in = make_word(8'h01, 3'b100, 16'd999, 48'h1, 32'h1);
        step();
        data_in = '0;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stat_clr_wins", cnt_ddos, 0);
        data_in = make_word(8'h01, 3'b011, 16'd5, 48'h1, 32'h1);
        step();
        data_in = '0;
        step();
        check("stat_ddos_after", cnt_ddos, 0);
        check("stat_arp_one", cnt_arp, 1);
        check("stat_pscan_one", cnt_pscan, 1);
        data_in = make_word(8'h03, 3'b100, 16'd5, 48'h1, 32'h1);
        step();
        data_in = '0;
        step();
        check("stat_malformed_one", cnt_malformed, 1);
        rec_ready = 1'b0;
`endif

        // Randomized traffic against the reference model
        do_reset();
        begin
            int stall_bias;
            stall_bias = 0;
            for (int c = 0; c < 3000; c++) begin
                int r;
                logic [127:0] w;
                r = $urandom_range(0, 9);
                if (c % 300 == 0) stall_bias = $urandom_range(0, 3);
                w = make_word(8'($urandom_range(1, 2)), 3'($urandom_range(1, 7)), 16'($urandom),
                              {16'($urandom), 32'($urandom)}, 32'($urandom));
                case (r)
                    0, 1:    data_in = '0;
                    2, 3:    data_in = data_in;
                    4, 5, 6: data_in = w;
                    7:       data_in = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
                    8: begin
                        if ($urandom_range(0, 1) == 1) w[$urandom_range(112, 127)] = 1'b1;
                        else w[$urandom_range(99, 103)] = 1'b1;
                        data_in = w;
                    end
                    default: begin
                        if ($urandom_range(0, 1) == 1) w[98:96] = 3'b000;
                        else w[111:104] = 8'($urandom_range(3, 255));
                        data_in = w;
                    end
                endcase
                rec_ready = ($urandom_range(0, 3) >= stall_bias);
                model_and_step();
                compare_model();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
